// File: rtl/ysyx_23060059_icache.sv
// Direct-mapped, read-only instruction cache between the IFU fetch port and an AXI read channel.
// One request at a time; hits answer two cycles after the fetch handshake, misses refill the whole
// line with an INCR burst and forward the requested word as it streams past.
module ysyx_23060059_icache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fence_i,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [7:0]  mem_arlen,
    output logic [2:0]  mem_arsize,
    output logic [1:0]  mem_arburst,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    input  logic        mem_rlast,
    output logic        mem_rready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned WOFF_W = $clog2(WORDS);
    localparam int unsigned OFF_W  = WOFF_W + 2;
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
    // Beat counter is one bit wider so an over-long burst cannot alias back onto the last index.
    localparam logic [WOFF_W:0] LastBeat = (WOFF_W + 1)'(WORDS - 1);

    typedef enum logic [2:0] {StIdle, StLookup, StRefillAr, StRefillR, StResp} state_e;

    state_e            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              fence_pend_q, fence_pend_d;
    logic [29:0]       req_q, req_d;          // word address of the outstanding fetch
    logic [WOFF_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES][WORDS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WOFF_W-1:0] req_off;
    logic              hit;
    logic              beat_err;
    logic              data_we;
    logic              tag_we;
    logic              unused_addr_lsb;

    assign req_tag = req_q[29 -: TAG_W];
    assign req_idx = req_q[WOFF_W +: IDX_W];
    assign req_off = req_q[WOFF_W-1:0];
    assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign unused_addr_lsb = ^ifu_araddr[1:0];

    assign mem_araddr  = {req_tag, req_idx, {OFF_W{1'b0}}};
    assign mem_arlen   = 8'(WORDS - 1);
    assign mem_arsize  = 3'b010;
    assign mem_arburst = 2'b01;
    assign ifu_rdata   = rdata_q;
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

    // Next-state, handshake outputs and array write enables.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        fence_pend_d = fence_pend_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        ifu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        mem_arvalid  = 1'b0;
        mem_rready   = 1'b0;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        beat_err     = err_q | (mem_rresp != 2'b00);

        // A fence during a fetch is deferred so the in-flight fetch finishes with old contents.
        if (fence_i && (state_q != StIdle)) begin
            fence_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                ifu_arready = !fence_pend_q && !fence_i;
                if (fence_pend_q || fence_i) begin
                    valid_d      = '0;
                    fence_pend_d = 1'b0;
                end else if (ifu_arvalid) begin
                    req_d   = ifu_araddr[31:2];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    rdata_d   = data_mem[req_idx][req_off];
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = StResp;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = StRefillAr;
                end
            end
            StRefillAr: begin
                mem_arvalid = 1'b1;
                if (mem_arready) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StRefillR;
                end
            end
            StRefillR: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    data_we = !cnt_q[WOFF_W];
                    cnt_d   = cnt_q + 1'b1;
                    err_d   = beat_err;
                    if (cnt_q == {1'b0, req_off}) begin
                        rdata_d = mem_rdata;
                    end
                    if (mem_rlast) begin
                        // Short, long or faulty bursts leave the line invalid.
                        if ((cnt_q == LastBeat) && !beat_err) begin
                            valid_d[req_idx] = 1'b1;
                            tag_we           = 1'b1;
                        end else begin
                            valid_d[req_idx] = 1'b0;
                        end
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                ifu_rvalid = 1'b1;
                if (ifu_rready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!reset) begin
            ifu_arready = 1'b0;
            ifu_rvalid  = 1'b0;
            mem_arvalid = 1'b0;
            mem_rready  = 1'b0;
            data_we     = 1'b0;
            tag_we      = 1'b0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
            req_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fence_pend_q <= fence_pend_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag and data arrays; contents are only meaningful under their valid bit, so no reset.
    always_ff @(posedge clock) begin
        if (data_we) begin
            data_mem[req_idx][cnt_q[WOFF_W-1:0]] <= mem_rdata;
        end
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_ysyx_23060059_icache.sv
// Self-checking bench for ysyx_23060059_icache: a table of fetches, each acting as both IFU and
// memory, with expected words queued at the fetch handshake and popped at the response handshake.
module tb_ysyx_23060059_icache;
    localparam int WORDS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        fence_i;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid;
    logic        mem_rlast;
    logic        mem_rready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always #5 clock = ~clock;

    ysyx_23060059_icache dut (
        .clock       (clock),
        .reset       (reset),
        .fence_i     (fence_i),
        .ifu_araddr  (ifu_araddr),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_arlen   (mem_arlen),
        .mem_arsize  (mem_arsize),
        .mem_arburst (mem_arburst),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rvalid  (mem_rvalid),
        .mem_rlast   (mem_rlast),
        .mem_rready  (mem_rready),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        bit          pre_fence;     // pulse fence_i together with the request
        int          fence_beat;    // pulse fence_i alongside this refill beat, -1 = never
        int          err_beat;      // beat carrying rresp=2, -1 = none
        int          ar_delay;      // cycles mem_arready is withheld
        int          rready_delay;  // cycles ifu_rready is withheld
        int          blk;           // expected cycles before ifu_arready
        bit          hit;
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Backing memory contents: line number in the upper bits, (word+1)*0x11 in the low byte.
    function automatic logic [31:0] model(input logic [31:0] a);
        logic [31:0] w;
        w = {30'd0, a[3:2]};
        return {a[27:4], 8'h00} + (w + 32'd1) * 32'h11;
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input bit pre_fence, input int fence_beat,
                                input int err_beat, input int ar_delay, input int rready_delay,
                                input int blk, input bit hit, input logic [31:0] exp_hit,
                                input logic [31:0] exp_miss);
        vec_t v;
        v.addr = addr;       v.pre_fence = pre_fence; v.fence_beat = fence_beat;
        v.err_beat = err_beat; v.ar_delay = ar_delay; v.rready_delay = rready_delay;
        v.blk = blk;         v.hit = hit;             v.exp_hit = exp_hit; v.exp_miss = exp_miss;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        fence_i = 1'b0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after.
    task automatic do_fetch(input vec_t v);
        int          waits;
        int          k;
        int          beat;
        int          ar_wait;
        int          resp_wait;
        bit          ar_seen;
        bit          done;
        bit          rlast_prev;
        logic [31:0] line;
        logic [31:0] ar_addr_s;
        logic [31:0] rdata_s;
        line = v.addr & 32'hFFFF_FFF0;
        ifu_araddr = v.addr; ifu_arvalid = 1'b1; fence_i = v.pre_fence;
        #1;
        waits = 0;
        while (!ifu_arready && waits < 8) begin
            @(negedge clock);
            fence_i = 1'b0;
            #1;
            waits++;
        end
        check("arready_wait", 32'(waits), 32'(v.blk));
        if (!ifu_arready) begin
            clear_inputs();
            return;
        end
        sb_q.push_back(model(v.addr));
        k = 0; beat = 0; ar_wait = 0; resp_wait = 0;
        ar_seen = 1'b0; done = 1'b0; rlast_prev = 1'b0; ar_addr_s = '0; rdata_s = '0;
        while (!done && k < 60) begin
            @(negedge clock);
            clear_inputs();
            #1;
            k++;
            if (k == 1) check("lookup_quiet", {30'd0, ifu_rvalid, mem_arvalid}, 32'd0);
            if (k == 2) check("latency", {30'd0, ifu_rvalid, mem_arvalid}, v.hit ? 32'd2 : 32'd1);
            if (mem_arvalid) begin
                if (!ar_seen) begin
                    check("ar_addr", mem_araddr, line);
                    check("ar_const", {19'd0, mem_arlen, mem_arsize, mem_arburst},
                          {19'd0, 8'(WORDS - 1), 3'b010, 2'b01});
                    ar_addr_s = mem_araddr;
                    ar_seen   = 1'b1;
                end else begin
                    check("ar_stable", mem_araddr, ar_addr_s);
                end
                if (ar_wait >= v.ar_delay) mem_arready = 1'b1;
                else ar_wait++;
            end
            if (mem_rready && beat < WORDS) begin
                if (beat == v.fence_beat) fence_i = 1'b1;
                mem_rvalid = 1'b1;
                mem_rdata  = model(line + 32'(beat * 4));
                mem_rlast  = (beat == WORDS - 1);
                mem_rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
                beat++;
            end
            if (ifu_rvalid) begin
                if (resp_wait == 0) begin
                    if (!v.hit) check("rvalid_after_rlast", {31'd0, rlast_prev}, 32'd1);
                    rdata_s = ifu_rdata;
                end else begin
                    check("rdata_stable", ifu_rdata, rdata_s);
                end
                if (resp_wait >= v.rready_delay) begin
                    ifu_rready = 1'b1;
                    if (sb_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL scoreboard: response with empty queue, got 0x%08h", ifu_rdata);
                    end else begin
                        check("rdata", ifu_rdata, sb_q.pop_front());
                    end
                    done = 1'b1;
                end else begin
                    resp_wait++;
                end
            end
            rlast_prev = mem_rvalid && mem_rlast && mem_rready;
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: fetch 0x%08h got no response, expected one within 60 cycles", v.addr);
        end
        @(negedge clock);
        clear_inputs();
        #1;
        check("refill_issued", {31'd0, ar_seen}, {31'd0, !v.hit});
        check("hit_cnt", hit_cnt, v.exp_hit);
        check("miss_cnt", miss_cnt, v.exp_miss);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //                 addr          pf fb  eb  ard rrd blk hit hits   misses
        vecs.push_back(mk(32'h8000_0004, 0, -1, -1, 0,  0,  0,  0,  32'd0, 32'd1));
        vecs.push_back(mk(32'h8000_000C, 0, -1, -1, 0,  0,  0,  1,  32'd1, 32'd1));
        vecs.push_back(mk(32'h8000_0100, 0, -1, -1, 0,  0,  0,  0,  32'd1, 32'd2));
        vecs.push_back(mk(32'h8000_0000, 0, -1, -1, 0,  0,  0,  0,  32'd1, 32'd3));
        vecs.push_back(mk(32'h8000_0008, 0, -1, -1, 0,  3,  0,  1,  32'd2, 32'd3));
        vecs.push_back(mk(32'h8000_0010, 0, -1, -1, 2,  0,  0,  0,  32'd2, 32'd4));
        vecs.push_back(mk(32'h8000_0014, 0, -1, -1, 0,  1,  0,  1,  32'd3, 32'd4));
        vecs.push_back(mk(32'h8000_0030, 0,  1, -1, 0,  0,  0,  0,  32'd3, 32'd5));
        vecs.push_back(mk(32'h8000_0030, 0, -1, -1, 0,  0,  1,  0,  32'd3, 32'd6));
        vecs.push_back(mk(32'h8000_0034, 0, -1, -1, 0,  0,  0,  1,  32'd4, 32'd6));
        vecs.push_back(mk(32'h8000_0024, 0, -1,  1, 0,  0,  0,  0,  32'd4, 32'd7));
        vecs.push_back(mk(32'h8000_0024, 0, -1, -1, 0,  0,  0,  0,  32'd4, 32'd8));
        vecs.push_back(mk(32'h8000_0028, 0, -1, -1, 0,  0,  0,  1,  32'd5, 32'd8));
        vecs.push_back(mk(32'h8000_004C, 0, -1,  3, 0,  0,  0,  0,  32'd5, 32'd9));
        vecs.push_back(mk(32'h8000_0040, 0, -1, -1, 0,  0,  0,  0,  32'd5, 32'd10));
        vecs.push_back(mk(32'h8000_0044, 0, -1, -1, 0,  0,  0,  1,  32'd6, 32'd10));
        vecs.push_back(mk(32'h8000_0028, 1, -1, -1, 0,  0,  1,  0,  32'd6, 32'd11));

        reset = 1'b0; ifu_araddr = '0; mem_rdata = '0;
        clear_inputs();
        ifu_arvalid = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset_outputs", {28'd0, ifu_arready, ifu_rvalid, mem_arvalid, mem_rready}, 32'd0);
        check("reset_rdata", ifu_rdata, 32'd0);
        check("reset_counters", hit_cnt | miss_cnt, 32'd0);
        ifu_arvalid = 1'b0;
        reset = 1'b1;

        foreach (vecs[i]) do_fetch(vecs[i]);

        // Reset in the middle of a refill of line 5.
        ifu_araddr = 32'h8000_0050; ifu_arvalid = 1'b1;
        #1;
        check("rst_seq_arready", {31'd0, ifu_arready}, 32'd1);
        @(negedge clock);
        ifu_arvalid = 1'b0;
        #1;
        n = 0;
        while (!mem_arvalid && n < 5) begin
            @(negedge clock); #1; n++;
        end
        mem_arready = 1'b1;
        @(negedge clock);
        mem_arready = 1'b0;
        #1;
        check("rst_seq_rready", {31'd0, mem_rready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = model(32'h8000_0050);
        @(negedge clock);
        mem_rdata = model(32'h8000_0054);
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", {28'd0, ifu_arready, ifu_rvalid, mem_arvalid, mem_rready}, 32'd0);
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_mid_counters", hit_cnt | miss_cnt, 32'd0);
        check("rst_mid_rdata", ifu_rdata, 32'd0);
        do_fetch(mk(32'h8000_0050, 0, -1, -1, 0, 0, 0, 0, 32'd0, 32'd1));
        do_fetch(mk(32'h8000_000C, 0, -1, -1, 0, 0, 0, 0, 32'd0, 32'd2));
        do_fetch(mk(32'h8000_000C, 0, -1, -1, 0, 0, 0, 1, 32'd1, 32'd2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
